// File: rtl/dds_pkg.sv
// Shared constants and state encodings for the multi-channel DDS sequencer.
// DDS_PHASE_WORD_EN adds the CPOW0 state.
package dds_pkg;

    localparam logic [6:0] AddrCsr   = 7'h00;
    localparam logic [6:0] AddrFr1   = 7'h01;
    localparam logic [6:0] AddrCfr   = 7'h03;
    localparam logic [6:0] AddrCftw0 = 7'h04;
    localparam logic [6:0] AddrCpow0 = 7'h05;
    localparam logic [6:0] AddrAcr   = 7'h06;

    localparam logic [4:0] BytesCsr   = 5'd1;
    localparam logic [4:0] BytesFr1   = 5'd3;
    localparam logic [4:0] BytesCfr   = 5'd3;
    localparam logic [4:0] BytesCftw0 = 5'd4;
    localparam logic [4:0] BytesCpow0 = 5'd2;
    localparam logic [4:0] BytesAcr   = 5'd3;

    localparam int unsigned CsrLsbFirstBit = 0;
    localparam int unsigned CsrModeLsb     = 1;
    localparam int unsigned CsrChEnLsb     = 4;

    typedef enum logic [3:0] {
        StRst, StCsrAll, StFr1, StCfr, StIoupd, StIdle, StChCsr, StChFtw,
`ifdef DDS_PHASE_WORD_EN
        StChPow,
`endif
        StChAsf, StDone
    } dds_state_e;

    typedef enum logic [1:0] {TxIdle, TxTrig, TxSkip, TxWait} txn_state_e;

    function automatic logic [7:0] csr_word(input logic [3:0] en, input logic [1:0] mode);
        return (8'(en) << CsrChEnLsb) | (8'(mode) << CsrModeLsb) | (8'd1 << CsrLsbFirstBit);
    endfunction

endpackage

// File: rtl/dds_spi_txn.sv
// One SPI transfer: latch request, pulse trigger, wait out busy, strobe done.
// Busy is ignored on the cycle after trigger, since the engine may not have raised it yet.
module dds_spi_txn
    import dds_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [4:0]  req_bytes,
    input  logic [63:0] req_data,
    input  logic        busy,
    output logic        trigger,
    output logic [4:0]  packs_to_send,
    output logic [63:0] data_input,
    output logic        done
);

    txn_state_e state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= TxIdle;
            packs_to_send <= '0;
            data_input    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == TxIdle && req) begin
                packs_to_send <= req_bytes;
                data_input    <= req_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        trigger = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            TxIdle: if (req) state_d = TxTrig;
            TxTrig: begin
                trigger = 1'b1;
                state_d = TxSkip;
            end
            TxSkip: state_d = TxWait;
            TxWait: if (!busy) begin
                done    = 1'b1;
                state_d = TxIdle;
            end
            default: state_d = TxIdle;
        endcase
    end

endmodule

// File: rtl/dds_multi_channel_sequencer.sv
// AD995x sequencer: init, then per-channel writes of changed FTW/ASF words.
// Defining DDS_PHASE_WORD_EN adds a pow input and CPOW0 writes.
module dds_multi_channel_sequencer
    import dds_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter logic [1:0]  IO_MODE      = 2'b11,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned IOUPD_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [32*NUM_CH-1:0]   ftw,
    input  logic [24*NUM_CH-1:0]   asf,
`ifdef DDS_PHASE_WORD_EN
    input  logic [16*NUM_CH-1:0]   pow,
`endif
    input  logic                   vco_gain,
    input  logic [4:0]             clock_multiplier,
    input  logic [1:0]             dac_fscale,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    output logic                   upd_done,
    input  logic                   busy,
    output logic                   trigger,
    output logic [4:0]             packs_to_send,
    output logic [63:0]            data_input,
    output logic                   master_reset,
    output logic                   io_update,
    output logic                   init_done
);

    dds_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  ch_q, ch_d;
    logic        phase_q, phase_d;  // 0: instruction byte, 1: register data
    logic        pend_q, pend_d;
    logic        force_all_q, force_all_d;
    logic        init_done_q, init_done_d;
    logic        master_reset_q, io_update_q;

    logic [32*NUM_CH-1:0] ftw_w_q, ftw_sh_q;
    logic [24*NUM_CH-1:0] asf_w_q, asf_sh_q;
    logic [NUM_CH-1:0]    dirty_f_q, dirty_a_q, dirty_p, new_f, new_a, new_p;

    logic        is_write, req, txn_done, wr_done, accept;
    logic [6:0]  addr;
    logic [4:0]  nbytes;
    logic [63:0] payload;
    logic [2:0]  first_sel, next_sel;

`ifdef DDS_PHASE_WORD_EN
    logic [16*NUM_CH-1:0] pow_w_q, pow_sh_q;
    logic [NUM_CH-1:0]    dirty_p_q;
    assign dirty_p = dirty_p_q;
`else
    assign dirty_p = '0;
    assign new_p   = '0;
`endif

    // Returns {found, index} of the lowest set bit at or above 'from'.
    function automatic logic [2:0] first_dirty(input logic [NUM_CH-1:0] d, input int from);
        logic [2:0] r;
        r = '0;
        for (int n = int'(NUM_CH) - 1; n >= 0; n--) begin
            if (d[n] && n >= from) r = {1'b1, 2'(n)};
        end
        return r;
    endfunction

    always_comb begin
        for (int n = 0; n < int'(NUM_CH); n++) begin
            new_f[n] = force_all_q | (ftw[32*n +: 32] != ftw_sh_q[32*n +: 32]);
            new_a[n] = force_all_q | (asf[24*n +: 24] != asf_sh_q[24*n +: 24]);
`ifdef DDS_PHASE_WORD_EN
            new_p[n] = force_all_q | (pow[16*n +: 16] != pow_sh_q[16*n +: 16]);
`endif
        end
    end

    assign first_sel = first_dirty(new_f | new_a | new_p, 0);
    assign next_sel  = first_dirty(dirty_f_q | dirty_a_q | dirty_p, int'(ch_q) + 1);
    assign upd_ready = (state_q == StIdle);
    assign accept    = upd_ready && upd_valid;

    always_comb begin
        is_write = 1'b1;
        addr     = AddrCsr;
        nbytes   = BytesCsr;
        payload  = '0;
        unique case (state_q)
            StCsrAll: payload = 64'(csr_word(4'((5'd1 << NUM_CH) - 5'd1), IO_MODE));
            StFr1: begin
                addr    = AddrFr1;
                nbytes  = BytesFr1;
                payload = 64'({vco_gain, clock_multiplier, 18'b0});
            end
            StCfr: begin
                addr    = AddrCfr;
                nbytes  = BytesCfr;
                payload = 64'({dac_fscale, 8'b0});
            end
            StChCsr: payload = 64'(csr_word(4'(5'd1 << ch_q), IO_MODE));
            StChFtw: begin
                addr    = AddrCftw0;
                nbytes  = BytesCftw0;
                payload = 64'(ftw_w_q[32*ch_q +: 32]);
            end
`ifdef DDS_PHASE_WORD_EN
            StChPow: begin
                addr    = AddrCpow0;
                nbytes  = BytesCpow0;
                payload = 64'(pow_w_q[16*ch_q +: 16]);
            end
`endif
            StChAsf: begin
                addr    = AddrAcr;
                nbytes  = BytesAcr;
                payload = 64'(asf_w_q[24*ch_q +: 24]);
            end
            default: is_write = 1'b0;
        endcase
    end

    assign req     = is_write && !pend_q;
    assign wr_done = is_write && txn_done && phase_q;

    dds_spi_txn u_txn (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .req_bytes     (phase_q ? nbytes : 5'd1),
        .req_data      (phase_q ? payload : 64'(addr)),
        .busy          (busy),
        .trigger       (trigger),
        .packs_to_send (packs_to_send),
        .data_input    (data_input),
        .done          (txn_done)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        phase_d     = phase_q;
        pend_d      = pend_q;
        force_all_d = force_all_q;
        init_done_d = init_done_q;
        if (req) pend_d = 1'b1;
        if (is_write && txn_done) begin
            pend_d  = 1'b0;
            phase_d = ~phase_q;
        end
        unique case (state_q)
            StRst: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == RESET_CYCLES) state_d = StCsrAll;
            end
            StCsrAll: if (wr_done) state_d = StFr1;
            StFr1:    if (wr_done) state_d = StCfr;
            StCfr:    if (wr_done) state_d = StIoupd;
            StIoupd: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == IOUPD_CYCLES) begin
                    init_done_d = 1'b1;
                    state_d     = init_done_q ? StDone : StIdle;
                end
            end
            StIdle: if (accept) begin
                ch_d    = first_sel[1:0];
                state_d = first_sel[2] ? StChCsr : StDone;
            end
            StChCsr: if (wr_done) begin
                state_d = dirty_f_q[ch_q] ? StChFtw :
`ifdef DDS_PHASE_WORD_EN
                          dirty_p[ch_q] ? StChPow :
`endif
                          StChAsf;
            end
            StChFtw: if (wr_done) begin
                state_d = StChAsf;
`ifdef DDS_PHASE_WORD_EN
                if (dirty_p[ch_q]) state_d = StChPow;
                else
`endif
                if (!dirty_a_q[ch_q]) begin
                    ch_d    = next_sel[1:0];
                    state_d = next_sel[2] ? StChCsr : StIoupd;
                end
            end
`ifdef DDS_PHASE_WORD_EN
            StChPow: if (wr_done && !dirty_a_q[ch_q]) begin
                ch_d    = next_sel[1:0];
                state_d = next_sel[2] ? StChCsr : StIoupd;
            end else if (wr_done) begin
                state_d = StChAsf;
            end
`endif
            StChAsf: if (wr_done) begin
                ch_d    = next_sel[1:0];
                state_d = next_sel[2] ? StChCsr : StIoupd;
            end
            StDone: begin
                force_all_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StRst;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StRst;
            cnt_q          <= '0;
            ch_q           <= '0;
            phase_q        <= 1'b0;
            pend_q         <= 1'b0;
            force_all_q    <= 1'b1;
            init_done_q    <= 1'b0;
            master_reset_q <= 1'b0;
            io_update_q    <= 1'b0;
            ftw_w_q        <= '0;
            ftw_sh_q       <= '0;
            asf_w_q        <= '0;
            asf_sh_q       <= '0;
            dirty_f_q      <= '0;
            dirty_a_q      <= '0;
`ifdef DDS_PHASE_WORD_EN
            pow_w_q        <= '0;
            pow_sh_q       <= '0;
            dirty_p_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ch_q           <= ch_d;
            phase_q        <= phase_d;
            pend_q         <= pend_d;
            force_all_q    <= force_all_d;
            init_done_q    <= init_done_d;
            master_reset_q <= (state_q == StRst) && (cnt_q < RESET_CYCLES);
            io_update_q    <= (state_q == StIoupd) && (cnt_q < IOUPD_CYCLES);
            if (accept) begin
                ftw_w_q   <= ftw;
                asf_w_q   <= asf;
                dirty_f_q <= new_f;
                dirty_a_q <= new_a;
`ifdef DDS_PHASE_WORD_EN
                pow_w_q   <= pow;
                dirty_p_q <= new_p;
`endif
            end
            if (wr_done && state_q == StChFtw) ftw_sh_q[32*ch_q +: 32] <= ftw_w_q[32*ch_q +: 32];
            if (wr_done && state_q == StChAsf) asf_sh_q[24*ch_q +: 24] <= asf_w_q[24*ch_q +: 24];
`ifdef DDS_PHASE_WORD_EN
            if (wr_done && state_q == StChPow) pow_sh_q[16*ch_q +: 16] <= pow_w_q[16*ch_q +: 16];
`endif
        end
    end

    assign upd_done     = (state_q == StDone);
    assign master_reset = master_reset_q;
    assign io_update    = io_update_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_dds_multi_channel_sequencer.sv
// Directed bench for dds_multi_channel_sequencer (NUM_CH=2) with a 10-cycle busy model.
// Covers the DDS_PHASE_WORD_EN build when that macro is defined.
module tb_dds_multi_channel_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] ftw = '0;
    logic [47:0] asf = '0;
`ifdef DDS_PHASE_WORD_EN
    logic [31:0] pow = '0;
`endif
    logic        vco_gain = 1'b1;
    logic [4:0]  clock_multiplier = 5'd20;
    logic [1:0]  dac_fscale = 2'd2;
    logic        upd_valid = 1'b0;
    logic        upd_ready, upd_done, busy, trigger, master_reset, io_update, init_done;
    logic [4:0]  packs_to_send;
    logic [63:0] data_input;

    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int mr_cyc = 0, iou_cyc = 0, iou_pulses = 0, done_cnt = 0;
    logic iou_prev = 1'b0;
    logic [68:0] log_q[$];
    logic [68:0] exp_q[$];

    dds_multi_channel_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .ftw              (ftw),
        .asf              (asf),
`ifdef DDS_PHASE_WORD_EN
        .pow              (pow),
`endif
        .vco_gain         (vco_gain),
        .clock_multiplier (clock_multiplier),
        .dac_fscale       (dac_fscale),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_done         (upd_done),
        .busy             (busy),
        .trigger          (trigger),
        .packs_to_send    (packs_to_send),
        .data_input       (data_input),
        .master_reset     (master_reset),
        .io_update        (io_update),
        .init_done        (init_done)
    );

    always #5 clock = ~clock;

    // SPI engine stand-in: busy for 10 cycles starting the cycle after trigger.
    always @(posedge clock or posedge reset) begin
        if (reset) busy_cnt <= 0;
        else if (trigger) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign busy = (busy_cnt != 0);

    always @(negedge clock) begin
        if (!reset) begin
            if (trigger) log_q.push_back({packs_to_send, data_input});
            if (master_reset) mr_cyc++;
            if (io_update) iou_cyc++;
            if (io_update && !iou_prev) iou_pulses++;
            if (upd_done) done_cnt++;
        end
        iou_prev = io_update;
    end

    task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        log_q.delete();
        exp_q.delete();
        mr_cyc = 0;
        iou_cyc = 0;
        iou_pulses = 0;
        done_cnt = 0;
    endtask

    task automatic exp_write(input logic [6:0] addr, input logic [4:0] nb, input logic [63:0] d);
        exp_q.push_back({5'd1, 64'(addr)});
        exp_q.push_back({nb, d});
    endtask

    task automatic exp_full_ch(input logic [7:0] csr, input logic [31:0] f, input logic [23:0] a);
        exp_write(7'h00, 5'd1, 64'(csr));
        exp_write(7'h04, 5'd4, 64'(f));
`ifdef DDS_PHASE_WORD_EN
        exp_write(7'h05, 5'd2, 64'h0);
`endif
        exp_write(7'h06, 5'd3, 64'(a));
    endtask

    task automatic exp_init();
        exp_write(7'h00, 5'd1, 64'h37);
        exp_write(7'h01, 5'd3, 64'hD00000);
        exp_write(7'h03, 5'd3, 64'h000200);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, 69'(log_q.size()), 69'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), (i < log_q.size()) ? log_q[i] : '1, exp_q[i]);
    endtask

    task automatic wait_init();
        for (int i = 0; i < 3000 && !init_done; i++) @(negedge clock);
        chk("init_done", 69'(init_done), 69'd1);
    endtask

    task automatic request_and_wait(input string tag);
        @(negedge clock);
        chk({tag, "_ready"}, 69'(upd_ready), 69'd1);
        upd_valid = 1'b1;
        @(negedge clock);
        upd_valid = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clock);
        repeat (4) @(negedge clock);
        chk({tag, "_done_pulses"}, 69'(done_cnt), 69'd1);
    endtask

    initial begin
        #12;
        chk("rst_master_reset", 69'(master_reset), 69'd0);
        chk("rst_outputs", {trigger, io_update, init_done, upd_ready, upd_done}, 69'd0);
        chk("rst_payload", {packs_to_send, data_input}, 69'd0);

        // Initialisation sequence
        @(negedge clock);
        reset = 1'b0;
        clear_mon();
        wait_init();
        repeat (2) @(negedge clock);
        exp_init();
        check_log("init");
        chk("init_mr_cycles", 69'(mr_cyc), 69'd4);
        chk("init_iou_cycles", 69'(iou_cyc), 69'd2);
        chk("init_iou_pulses", 69'(iou_pulses), 69'd1);
        chk("init_ready", 69'(upd_ready), 69'd1);

        // First update writes everything; ftw0 is changed mid-sequence and must be ignored
        clear_mon();
        ftw = {32'h0ABCDEF0, 32'h12345678};
        asf = {24'h0013FF, 24'h0013FF};
        fork
            request_and_wait("upd1");
            begin
                repeat (20) @(negedge clock);
                ftw[31:0] = 32'hDEADBEEF;
            end
        join
        exp_full_ch(8'h17, 32'h12345678, 24'h0013FF);
        exp_full_ch(8'h27, 32'h0ABCDEF0, 24'h0013FF);
        check_log("upd1");
        chk("upd1_iou_pulses", 69'(iou_pulses), 69'd1);
        chk("upd1_iou_cycles", 69'(iou_cyc), 69'd2);

        // Only ftw1 changed
        clear_mon();
        ftw = {32'h11111111, 32'h12345678};
        request_and_wait("upd2");
        exp_write(7'h00, 5'd1, 64'h27);
        exp_write(7'h04, 5'd4, 64'h11111111);
        check_log("upd2");
        chk("upd2_iou_pulses", 69'(iou_pulses), 69'd1);

        // Identical request with upd_valid held: accept every other cycle, no SPI traffic
        clear_mon();
        @(negedge clock);
        chk("same_ready", 69'(upd_ready), 69'd1);
        upd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("held_done_%0d", i), 69'(upd_done), 69'((i % 2) == 0));
        end
        upd_valid = 1'b0;
        repeat (5) @(negedge clock);
        chk("same_triggers", 69'(log_q.size()), 69'd0);
        chk("same_iou_pulses", 69'(iou_pulses), 69'd0);
        chk("same_done_pulses", 69'(done_cnt), 69'd3);

        // Reset while the CFTW0 data transfer is in flight
        clear_mon();
        ftw[31:0] = 32'h55555555;
        @(negedge clock);
        upd_valid = 1'b1;
        @(negedge clock);
        upd_valid = 1'b0;
        for (int i = 0; i < 3000 && !(trigger && packs_to_send == 5'd4); i++) @(negedge clock);
        chk("mid_cftw0_seen", 69'(packs_to_send), 69'd4);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_outputs", {trigger, io_update, master_reset, init_done, upd_ready, upd_done},
            69'd0);
        chk("mid_rst_payload", {packs_to_send, data_input}, 69'd0);
        @(negedge clock);
        reset = 1'b0;
        clear_mon();
        wait_init();
        repeat (2) @(negedge clock);
        exp_init();
        check_log("reinit");
        chk("reinit_mr_cycles", 69'(mr_cyc), 69'd4);

        // force_all after reset: every word written again
        clear_mon();
        request_and_wait("upd3");
        exp_full_ch(8'h17, 32'h55555555, 24'h0013FF);
        exp_full_ch(8'h27, 32'h11111111, 24'h0013FF);
        check_log("upd3");
        chk("upd3_iou_pulses", 69'(iou_pulses), 69'd1);

`ifdef DDS_PHASE_WORD_EN
        clear_mon();
        pow[15:0] = 16'h2000;
        request_and_wait("pow");
        exp_write(7'h00, 5'd1, 64'h17);
        exp_write(7'h05, 5'd2, 64'h2000);
        check_log("pow");
        chk("pow_iou_pulses", 69'(iou_pulses), 69'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_multi_channel_sequencer.md
Name: dds_multi_channel_sequencer

Overview:
Parametrised successor to the dual-channel DDS core. It drives an AD995x-family DDS (1–4 channels) through the existing SPI shifter (trigger/busy/packs_to_send/data_input) and adds:
- an explicit update handshake
- per-word change detection, so only modified FTW/ASF words are written
- configurable reset and IO_UPDATE pulse widths

It sits between the host-side tuning-word buffers and the SPI engine.

Parameters:
NUM_CH, 2, number of DDS channels sequenced (1..4)
IO_MODE, 2'b11, CSR serial-mode field (bits 2:1); 2'b11 = 4-bit mode
RESET_CYCLES, 4, master_reset pulse width in clocks (>=1)
IOUPD_CYCLES, 2, io_update pulse width in clocks (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ftw  in  32*NUM_CH  frequency tuning words, channel n at [32n+31:32n]
asf  in  24*NUM_CH  ACR words, channel n at [24n+23:24n]
vco_gain  in  1  FR1 bit 23
clock_multiplier  in  5  FR1 bits 22:18
dac_fscale  in  2  CFR bits 9:8, written to all channels
upd_valid  in  1  host requests a tuning update
upd_ready  out  1  sequencer idle and able to accept
upd_done  out  1  1-cycle pulse after the closing io_update
busy  in  1  SPI engine busy
trigger  out  1  1-cycle SPI start pulse
packs_to_send  out  5  byte count of current transfer
data_input  out  64  transfer payload, LSB-aligned
master_reset  out  1  DDS master reset
io_update  out  1  DDS IO_UPDATE
init_done  out  1  initialisation complete

Behaviour:
- Interface decision: one clock (clock); reset is asynchronous and active-high (reset). All flops clear on reset assertion.
- Reset values: all outputs 0, state RST, shadow registers 0, force_all=1.
- Reset mid-transfer: sequencer restarts from RST; the SPI engine is not otherwise signalled.
- Register map:
  - CSR 0x00, 1 byte
  - FR1 0x01, 3 bytes
  - CFR 0x03, 3 bytes
  - CFTW0 0x04, 4 bytes
  - ACR 0x06, 3 bytes
  - Instruction byte = address with bit7=0, 1 byte.
- SPI transaction: every instruction or data write asserts trigger for exactly 1 cycle with data_input/packs_to_send valid that cycle, then enters WAIT. WAIT ignores busy on the cycle after trigger and advances once busy==0.
- Initialisation states:
  - RST: master_reset=1 for RESET_CYCLES.
  - CSR_ALL: CSR = all NUM_CH enable bits | IO_MODE<<1 | LSB-first (bit0=1).
  - FR1: (vco_gain<<23)|(clock_multiplier<<18).
  - CFR: dac_fscale<<8.
  - IOUPD: io_update=1 for IOUPD_CYCLES.
  - Then init_done=1, enter IDLE.
- Update path:
  - IDLE: upd_ready=1.
  - On upd_valid&&upd_ready, capture ftw/asf into working registers; dirty[n] = (ftw/asf differs from shadow) | force_all.
  - For each channel n ascending with any dirty word: CSR (enable bit 4+n only), then CFTW0 if FTW dirty, then ACR if ASF dirty. Shadows update as each write completes.
  - After the last write: IOUPD, pulse upd_done, clear force_all, return to IDLE.
- Boundary conditions:
  - No dirty words: skip SPI and IOUPD entirely; pulse upd_done 1 cycle after accept.
  - upd_valid held high: a new request is accepted only on the cycle after return to IDLE.
  - Inputs changing mid-sequence: ignored, since working registers are used.
  - NUM_CH=1: channel loop degenerates to a single pass.

Optional Feature:
- Macro: DDS_PHASE_WORD_EN.
- When defined:
  - Adds input pow (16*NUM_CH).
  - Each channel may also write CPOW0 (0x05, 2 bytes) after CFTW0, with its own dirty bit and shadow.
  - CFTW0 → CPOW0 → ACR order within a channel.
- When undefined: pow port, shadows and state are absent; behaviour exactly as above.

Decomposition:
- Package dds_pkg: register address and byte-size constants, the CSR field positions, and the state enumeration.
- One sub-module, dds_spi_txn: drives the trigger pulse and the WAIT/busy handshake and returns a done strobe; the main FSM issues (bytes, payload) requests to it.

Test Plan:
- Reset, busy model 10-cycle: master_reset high 4 cycles → transfers 00/CSR F0|07→ wait, byte sequence 0x00,0x37; 0x01,FR1; 0x03,0x000200 (dac_fscale=2) → io_update 2 cycles → init_done=1.
- First update, ftw0=0x12345678, ftw1=0x0ABCDEF0, asf=0x0013FF each → full write: CSR 0x17, CFTW0, ACR for ch0 then CSR 0x27 for ch1 → one io_update, upd_done.
- Repeat with only ftw1 changed to 0x11111111 → only CSR 0x27, instr 0x04, 0x11111111, io_update; no ch0 traffic.
- Identical repeat request → no trigger, no io_update, upd_done 1 cycle after accept.
- Assert reset while busy mid-CFTW0 → outputs zero immediately; full init replays; next update writes all words (force_all).
- With DDS_PHASE_WORD_EN, pow0 0x0000→0x2000 only → CSR 0x17, instr 0x05, 2-byte 0x2000, io_update.
